// File: rtl/adc_tlc549_bcd.sv
// adc_tlc549_bcd: periodically reads a TLC549-style 8-bit serial ADC, scales the
// sample to millivolts against VREF_MV and converts it to BCD with a sequential
// double-dabble. The display word is {raw hex (2 digits), mV BCD (4 digits)}.
// The first frame after reset is discarded because the device returns the result
// of the previous (unknown) conversion.
module adc_tlc549_bcd #(
  parameter int CLK_HALF      = 25,
  parameter int CS_SETUP      = 75,
  parameter int CONV_WAIT     = 1000,
  parameter int SAMPLE_PERIOD = 5_000_000,
  parameter int VREF_MV       = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_clk,
  output logic [23:0] data,
  output logic        data_valid
);

  localparam int TW   = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WMAX = (CONV_WAIT > CS_SETUP)
                        ? ((CONV_WAIT > CLK_HALF) ? CONV_WAIT : CLK_HALF)
                        : ((CS_SETUP > CLK_HALF) ? CS_SETUP : CLK_HALF);
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0] SETUP_LAST = WW'(CS_SETUP - 1);
  localparam logic [WW-1:0] HALF_LAST  = WW'(CLK_HALF - 1);
  localparam logic [WW-1:0] CONV_LAST  = WW'(CONV_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_CONV  = 3'd3,
    S_CALC  = 3'd4,
    S_BCD   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] timer_r;
  logic          tick_r;
  logic [WW-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]    bit_r, bit_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic [7:0]    raw_r, raw_nxt_s;
  logic [13:0]   mv_r, mv_nxt_s;
  logic [15:0]   bcd_r, bcd_nxt_s;
  logic [3:0]    bcnt_r, bcnt_nxt_s;
  logic          first_done_r, first_nxt_s;
  logic          cs_n_r, cs_n_nxt_s;
  logic          aclk_r, aclk_nxt_s;
  logic [23:0]   data_r, data_nxt_s;
  logic          valid_r, valid_nxt_s;

  logic [20:0]   prod_s;
  logic [13:0]   mv_calc_s;
  logic [15:0]   bcd_adj_s;

  assign prod_s    = 21'(raw_r) * 21'(VREF_MV);
  assign mv_calc_s = 14'(prod_s >> 8);
  assign bcd_adj_s = bcd_adjust(bcd_r);

  assign adc_cs_n   = cs_n_r;
  assign adc_clk    = aclk_r;
  assign data       = data_r;
  assign data_valid = valid_r;

  // Free-running sample period timer; tick pulses for one cycle after each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
      tick_r  <= 1'b0;
    end else if (timer_r == TIMER_LAST) begin
      timer_r <= '0;
      tick_r  <= 1'b1;
    end else begin
      timer_r <= timer_r + 1'b1;
      tick_r  <= 1'b0;
    end
  end

  // State and datapath registers, all updated from the next-state logic below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      bit_r        <= 3'd0;
      shift_r      <= 8'h00;
      raw_r        <= 8'h00;
      mv_r         <= 14'd0;
      bcd_r        <= 16'h0000;
      bcnt_r       <= 4'd0;
      first_done_r <= 1'b0;
      cs_n_r       <= 1'b1;
      aclk_r       <= 1'b0;
      data_r       <= 24'h000000;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      bit_r        <= bit_nxt_s;
      shift_r      <= shift_nxt_s;
      raw_r        <= raw_nxt_s;
      mv_r         <= mv_nxt_s;
      bcd_r        <= bcd_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      first_done_r <= first_nxt_s;
      cs_n_r       <= cs_n_nxt_s;
      aclk_r       <= aclk_nxt_s;
      data_r       <= data_nxt_s;
      valid_r      <= valid_nxt_s;
    end
  end

  // Frame sequencing, serial capture, scaling and BCD conversion next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    raw_nxt_s   = raw_r;
    mv_nxt_s    = mv_r;
    bcd_nxt_s   = bcd_r;
    bcnt_nxt_s  = bcnt_r;
    first_nxt_s = first_done_r;
    cs_n_nxt_s  = cs_n_r;
    aclk_nxt_s  = aclk_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        aclk_nxt_s = 1'b0;
        if (tick_r) begin
          cs_n_nxt_s  = 1'b0;
          cnt_nxt_s   = '0;
          state_nxt_s = S_SETUP;
        end else begin
          cs_n_nxt_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end
      end

      S_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          cnt_nxt_s   = '0;
          bit_nxt_s   = 3'd0;
          state_nxt_s = S_SHIFT;
        end else begin
          cnt_nxt_s   = cnt_r + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = '0;
          if (!aclk_r) begin
            // Rising edge of the I/O clock: capture the bit the ADC is presenting.
            aclk_nxt_s  = 1'b1;
            shift_nxt_s = {shift_r[6:0], adc_dout};
          end else begin
            aclk_nxt_s = 1'b0;
            if (bit_r == 3'd7) begin
              cs_n_nxt_s  = 1'b1;
              raw_nxt_s   = shift_r;
              state_nxt_s = S_CONV;
            end else begin
              bit_nxt_s = bit_r + 3'd1;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end

      S_CONV: begin
        if (cnt_r == CONV_LAST) begin
          cnt_nxt_s = '0;
          if (!first_done_r) begin
            first_nxt_s = 1'b1;
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_CALC;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end

      S_CALC: begin
        mv_nxt_s    = mv_calc_s;
        bcd_nxt_s   = 16'h0000;
        bcnt_nxt_s  = 4'd0;
        state_nxt_s = S_BCD;
      end

      S_BCD: begin
        bcd_nxt_s = {bcd_adj_s[14:0], mv_r[13]};
        mv_nxt_s  = {mv_r[12:0], 1'b0};
        if (bcnt_r == 4'd13) begin
          data_nxt_s  = {raw_r, bcd_adj_s[14:0], mv_r[13]};
          valid_nxt_s = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          bcnt_nxt_s = bcnt_r + 4'd1;
        end
      end

      S_DONE: begin
        state_nxt_s = S_IDLE;
      end

      default: begin
        cs_n_nxt_s  = 1'b1;
        aclk_nxt_s  = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_tlc549_bcd.sv
// Scoreboard bench for adc_tlc549_bcd: a serial ADC model serves one byte per frame,
// the expected display word is computed arithmetically and queued, and a monitor
// compares it whenever data_valid pulses. Frame timing is observed alongside.
module tb_adc_tlc549_bcd;

  localparam int CLK_HALF      = 2;
  localparam int CS_SETUP      = 3;
  localparam int CONV_WAIT     = 5;
  localparam int SAMPLE_PERIOD = 200;
  localparam int VREF_MV       = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adc_dout;
  logic        adc_cs_n;
  logic        adc_clk;
  logic [23:0] data;
  logic        data_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  val_q[$];
  logic [23:0] exp_q[$];
  bit          skip_next = 1'b1;
  logic [7:0]  adc_sr = 8'h00;
  logic        cs_seen = 1'b1;

  int          cyc = 0;
  logic [23:0] last_data = 24'h000000;
  logic        prev_cs = 1'b1;
  logic        prev_aclk = 1'b0;
  bit          in_frame = 1'b0;
  bit          have_start = 1'b0;
  int          last_start = 0;
  int          low_cnt = 0;
  int          rises = 0;

  adc_tlc549_bcd #(
    .CLK_HALF     (CLK_HALF),
    .CS_SETUP     (CS_SETUP),
    .CONV_WAIT    (CONV_WAIT),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .VREF_MV      (VREF_MV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_dout  (adc_dout),
    .adc_cs_n  (adc_cs_n),
    .adc_clk   (adc_clk),
    .data      (data),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: millivolts by floor division, then decimal digits.
  function automatic logic [23:0] ref_word(input int v);
    int mv;
    logic [7:0] raw;
    mv  = (v * VREF_MV) / 256;
    raw = 8'(v);
    return {raw, 4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
  endfunction

  // ADC model: MSB presented at chip-select fall, next bit after each I/O clock fall.
  assign adc_dout = adc_sr[7];
  always @(adc_cs_n or negedge adc_clk) begin
    if (adc_cs_n === 1'b0 && cs_seen === 1'b1) begin
      if (rst_n === 1'b1) begin
        if (val_q.size() > 0) adc_sr = val_q.pop_front();
        else adc_sr = 8'h00;
        if (skip_next) skip_next = 1'b0;
        else exp_q.push_back(ref_word(int'(adc_sr)));
      end
    end else if (adc_cs_n === 1'b0) begin
      adc_sr = {adc_sr[6:0], 1'b0};
    end
    cs_seen = adc_cs_n;
  end

  // Monitor: scoreboard compare, data hold, and frame waveform checks.
  always @(negedge clk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      last_data  = 24'h000000;
      in_frame   = 1'b0;
      have_start = 1'b0;
    end else begin
      if (data_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(data_valid), 32'd0);
        else check("data", 32'(data), 32'(exp_q.pop_front()));
        last_data = data;
      end else begin
        check("data_hold", 32'(data), 32'(last_data));
      end
      check("clk_while_cs_high", 32'(adc_cs_n & adc_clk), 32'd0);
      if (prev_cs && !adc_cs_n) begin
        if (have_start) check("frame_spacing", 32'(cyc - last_start), 32'(SAMPLE_PERIOD));
        have_start = 1'b1;
        last_start = cyc;
        in_frame   = 1'b1;
        low_cnt    = 1;
        rises      = 0;
      end else if (!adc_cs_n && in_frame) begin
        low_cnt++;
      end
      if (in_frame && !prev_aclk && adc_clk) rises++;
      if (in_frame && !prev_cs && adc_cs_n) begin
        check("cs_low_cycles", 32'(low_cnt), 32'(CS_SETUP + 16 * CLK_HALF));
        check("clk_rises", 32'(rises), 32'd8);
        in_frame = 1'b0;
      end
    end
    prev_cs   = adc_cs_n;
    prev_aclk = adc_clk;
  end

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (val_q.size() != 0 || exp_q.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 32'(val_q.size() == 0 && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    int i;
    rst_n = 1'b0;
    skip_next = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_adc_clk", 32'(adc_clk), 32'd0);
    check("rst_data", 32'(data), 32'h000000);
    check("rst_valid", 32'(data_valid), 32'd0);

    // First 0x80 is discarded, then directed corner values, a held value, random.
    val_q.push_back(8'h80); val_q.push_back(8'h80);
    val_q.push_back(8'hFF); val_q.push_back(8'h00);
    val_q.push_back(8'h33);
    for (int k = 0; k < 3; k++) val_q.push_back(8'h5A);
    for (int k = 0; k < 10; k++) val_q.push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    rst_n = 1'b1;
    drain(25 * SAMPLE_PERIOD);

    // Reset in the middle of the serial shift.
    i = 0;
    while (i < 2 * SAMPLE_PERIOD && adc_cs_n !== 1'b0) begin
      @(negedge clk);
      i++;
    end
    check("wait_frame_timeout", 32'(adc_cs_n), 32'd0);
    repeat (CS_SETUP + 9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
    check("midrst_adc_clk", 32'(adc_clk), 32'd0);
    check("midrst_data", 32'(data), 32'h000000);
    exp_q.delete();
    val_q.delete();
    skip_next = 1'b1;
    val_q.push_back(8'h77);
    val_q.push_back(8'hC4);
    val_q.push_back(8'h01);
    for (int k = 0; k < 3; k++) val_q.push_back(8'($urandom_range(0, 255)));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain(10 * SAMPLE_PERIOD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
